softex_acc_row_sched: RTL and testbench
=======================================

# softex_acc_row_sched

Row-level scheduler in front of `softex_acc_top`. It accepts one row descriptor at a time (element count plus tag) and gates the addend/multiplier streams into the accumulator. It counts elements, requests the final inversion after the last addend, captures the accumulator result into a one-entry output buffer, and clears the accumulator before admitting the next row.

## Interface
- `ADD_WIDTH`, default 32: addend / multiplier / result width.
- `LEN_WIDTH`, default 16: row-length counter width.
- `ID_WIDTH`, default 4: row tag width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous soft clear; same effect as reset.
- `row_valid_i` in 1: row descriptor valid.
- `row_ready_o` out 1: descriptor accepted; high only in IDLE.
- `row_len_i` in LEN_WIDTH: number of addends in the row.
- `row_id_i` in ID_WIDTH: row tag.
- `in_add_valid_i` in 1: upstream addend valid.
- `in_add_ready_o` out 1: upstream addend ready.
- `in_add_i` in ADD_WIDTH: addend.
- `in_mul_valid_i` in 1: rescale factor valid.
- `in_mul_i` in ADD_WIDTH: rescale factor.
- `acc_add_valid_o` out 1: addend to accumulator.
- `acc_add_o` out ADD_WIDTH: addend to accumulator.
- `acc_mul_valid_o` out 1: rescale factor to accumulator.
- `acc_mul_o` out ADD_WIDTH: rescale factor to accumulator.
- `acc_ready_i` in 1: accumulator ready.
- `acc_last_o` out 1: qualifies the final addend of the row.
- `acc_invert_o` out 1: one-cycle inversion request.
- `acc_clear_o` out 1: one-cycle accumulator clear.
- `acc_valid_i` in 1: accumulator result valid.
- `acc_i` in ADD_WIDTH: accumulator result.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result ready.
- `res_o` out ADD_WIDTH: result.
- `res_id_o` out ID_WIDTH: result row tag.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, ACCUM, INVERT, WAIT, OUT, CLR.
- IDLE:
  - `row_ready_o`=1.
  - On `row_valid_i`, latch len and id and set the count to 0.
  - If len≠0, go to ACCUM.
  - If len==0, load `res_o`=0 and go to OUT. The accumulator is untouched.
- ACCUM:
  - Pass-through: `in_add_ready_o`=`acc_ready_i`; `acc_add_valid_o`=`in_add_valid_i`; `acc_add_o`=`in_add_i`.
  - Count increments on each addend handshake.
  - `acc_last_o`=1 when count==len−1.
  - The handshake of the last addend moves the FSM to INVERT.
  - `acc_mul_valid_o`=`in_mul_valid_i`, gated by ACCUM only. A simultaneous mul and add in the same cycle are both forwarded.
- INVERT: assert `acc_invert_o` for exactly one cycle, then go to WAIT.
- WAIT: on `acc_valid_i`, capture `acc_i` into the result register and go to OUT. The result is held; the accumulator is not re-read.
- OUT:
  - `res_valid_o`=1; `res_o` and `res_id_o` stay stable until `res_ready_i`.
  - On the handshake, go to CLR; for a len==0 row, go directly to IDLE.
- CLR: `acc_clear_o` for one cycle, then go to IDLE.
- Outside the relevant states, all `acc_*_valid_o`, `in_add_ready_o`, `acc_last_o`, `acc_invert_o` and `acc_clear_o` are 0.
- `acc_valid_i` outside WAIT is ignored.
- `in_mul_valid_i` outside ACCUM is dropped (no backpressure).
- Counter arithmetic is unsigned LEN_WIDTH with no wrap; len max is 2^LEN_WIDTH−1.

## Timing
- Reset / `clear_i`:
  - State → IDLE; count, len and id → 0.
  - `res_o` → 0, `res_valid_o` → 0, `busy_o` → 0.
  - All `acc_*` strobes → 0; `row_ready_o` → 1.
- Mid-row `clear_i` aborts the row without emitting a result. The accumulator is expected to be cleared by the same `clear_i`.
- Addend path is combinational pass-through (0-cycle latency). `acc_last_o` is combinational from the count.
- Last addend handshake at cycle t → `acc_invert_o` high at t+1 → WAIT from t+2.
- `acc_valid_i` at cycle w → `res_valid_o` high from w+1.
- Result handshake at r → `acc_clear_o` at r+1 → `row_ready_o` at r+2.
- Minimum row-to-row overhead is 4 cycles plus accumulator inversion latency.

## Structure
- Add an FSM state enum `acc_sched_state_e` to `softex_pkg`.
- Single module, no sub-module; the result register is inline.

## Test plan
- Row len=4, id=3, addends streamed with `acc_ready_i`=1:
  - `acc_last_o` on the 4th addend; `acc_invert_o` one cycle later.
  - `acc_valid_i` with 0x3F800000 → `res_o`=0x3F800000, `res_id_o`=3.
  - `acc_clear_o` after `res_ready_i`.
- Same row with `acc_ready_i` toggling every cycle: exactly 4 handshakes counted, no duplicate or lost addend, `acc_last_o` only on the 4th.
- len=0, id=5: `res_valid_o`=1 with `res_o`=0 and `res_id_o`=5 the cycle after acceptance; no `acc_invert_o` or `acc_clear_o` pulse.
- Hold `res_ready_i`=0 for 10 cycles in OUT: `res_o` and `res_id_o` stable, `row_ready_o`=0; a new descriptor is not accepted until CLR completes.
- `clear_i` after 2 of 8 addends: FSM in IDLE next cycle, no `res_valid_o`; the next row of len=1 completes normally.
- `in_mul_valid_i` concurrent with an addend in ACCUM: both forwarded. `in_mul_valid_i` in WAIT: `acc_mul_valid_o` stays 0.

Source files
------------

// File: rtl/softex_pkg.sv
// Shared types for the softex accumulator datapath.
package softex_pkg;

  // Row scheduler FSM states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccum  = 3'd1,
    StInvert = 3'd2,
    StWait   = 3'd3,
    StOut    = 3'd4,
    StClr    = 3'd5
  } acc_sched_state_e;

endpackage

// File: rtl/softex_acc_row_sched.sv
// Row scheduler in front of softex_acc_top: admits one row descriptor at a time,
// gates addends/rescale factors into the accumulator, requests the final inversion,
// buffers the result and clears the accumulator before the next row.
module softex_acc_row_sched
  import softex_pkg::*;
#(
  parameter int unsigned ADD_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned ID_WIDTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 row_valid_i,
  output logic                 row_ready_o,
  input  logic [LEN_WIDTH-1:0] row_len_i,
  input  logic [ID_WIDTH-1:0]  row_id_i,
  input  logic                 in_add_valid_i,
  output logic                 in_add_ready_o,
  input  logic [ADD_WIDTH-1:0] in_add_i,
  input  logic                 in_mul_valid_i,
  input  logic [ADD_WIDTH-1:0] in_mul_i,
  output logic                 acc_add_valid_o,
  output logic [ADD_WIDTH-1:0] acc_add_o,
  output logic                 acc_mul_valid_o,
  output logic [ADD_WIDTH-1:0] acc_mul_o,
  input  logic                 acc_ready_i,
  output logic                 acc_last_o,
  output logic                 acc_invert_o,
  output logic                 acc_clear_o,
  input  logic                 acc_valid_i,
  input  logic [ADD_WIDTH-1:0] acc_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ADD_WIDTH-1:0] res_o,
  output logic [ID_WIDTH-1:0]  res_id_o,
  output logic                 busy_o
);

  localparam logic [LEN_WIDTH-1:0] LenOne = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  acc_sched_state_e       state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ADD_WIDTH-1:0]   res_q, res_d;
  logic                   zero_row_q, zero_row_d;

  logic                   is_last;
  logic                   add_hs;

  // Last-addend flag is purely a function of the count, independent of valid/ready.
  assign is_last = (cnt_q == (len_q - LenOne));
  assign add_hs  = (state_q == StAccum) && in_add_valid_i && acc_ready_i;

  // Next-state logic for the FSM and the row bookkeeping registers.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    res_d      = res_q;
    zero_row_d = zero_row_q;
    unique case (state_q)
      StIdle: begin
        if (row_valid_i) begin
          len_d      = row_len_i;
          id_d       = row_id_i;
          cnt_d      = '0;
          zero_row_d = (row_len_i == '0);
          if (row_len_i == '0) begin
            // Empty row: emit a zero result without touching the accumulator.
            res_d   = '0;
            state_d = StOut;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (add_hs) begin
          cnt_d = cnt_q + LenOne;
          if (is_last) state_d = StInvert;
        end
      end
      StInvert: state_d = StWait;
      StWait: begin
        if (acc_valid_i) begin
          res_d   = acc_i;
          state_d = StOut;
        end
      end
      StOut: begin
        if (res_ready_i) state_d = zero_row_q ? StIdle : StClr;
      end
      StClr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; clear_i behaves exactly like reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      res_q      <= '0;
      zero_row_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      res_q      <= '0;
      zero_row_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      res_q      <= res_d;
      zero_row_q <= zero_row_d;
    end
  end

  // State-gated outputs; the addend path is a combinational pass-through in ACCUM.
  always_comb begin
    row_ready_o     = (state_q == StIdle);
    in_add_ready_o  = (state_q == StAccum) && acc_ready_i;
    acc_add_valid_o = (state_q == StAccum) && in_add_valid_i;
    acc_add_o       = in_add_i;
    acc_mul_valid_o = (state_q == StAccum) && in_mul_valid_i;
    acc_mul_o       = in_mul_i;
    acc_last_o      = (state_q == StAccum) && is_last;
    acc_invert_o    = (state_q == StInvert);
    acc_clear_o     = (state_q == StClr);
    res_valid_o     = (state_q == StOut);
    res_o           = res_q;
    res_id_o        = id_q;
    busy_o          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_softex_acc_row_sched.sv
// Directed self-checking bench for softex_acc_row_sched.
module tb_softex_acc_row_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        row_valid_i = 1'b0;
  logic        row_ready_o;
  logic [15:0] row_len_i = '0;
  logic [3:0]  row_id_i = '0;
  logic        in_add_valid_i = 1'b0;
  logic        in_add_ready_o;
  logic [31:0] in_add_i = '0;
  logic        in_mul_valid_i = 1'b0;
  logic [31:0] in_mul_i = '0;
  logic        acc_add_valid_o;
  logic [31:0] acc_add_o;
  logic        acc_mul_valid_o;
  logic [31:0] acc_mul_o;
  logic        acc_ready_i = 1'b0;
  logic        acc_last_o;
  logic        acc_invert_o;
  logic        acc_clear_o;
  logic        acc_valid_i = 1'b0;
  logic [31:0] acc_i = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_o;
  logic [3:0]  res_id_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  softex_acc_row_sched dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .row_valid_i     (row_valid_i),
    .row_ready_o     (row_ready_o),
    .row_len_i       (row_len_i),
    .row_id_i        (row_id_i),
    .in_add_valid_i  (in_add_valid_i),
    .in_add_ready_o  (in_add_ready_o),
    .in_add_i        (in_add_i),
    .in_mul_valid_i  (in_mul_valid_i),
    .in_mul_i        (in_mul_i),
    .acc_add_valid_o (acc_add_valid_o),
    .acc_add_o       (acc_add_o),
    .acc_mul_valid_o (acc_mul_valid_o),
    .acc_mul_o       (acc_mul_o),
    .acc_ready_i     (acc_ready_i),
    .acc_last_o      (acc_last_o),
    .acc_invert_o    (acc_invert_o),
    .acc_clear_o     (acc_clear_o),
    .acc_valid_i     (acc_valid_i),
    .acc_i           (acc_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_o           (res_o),
    .res_id_o        (res_id_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int hs;
    // Reset state.
    #12;
    rst_ni = 1'b1;
    step();
    check("rst_row_ready", 32'(row_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_strobes", {28'd0, acc_invert_o, acc_clear_o, acc_last_o, acc_add_valid_o}, 32'd0);

    // acc_valid_i outside WAIT must be ignored.
    acc_valid_i = 1'b1; acc_i = 32'hDEADBEEF;
    step();
    acc_valid_i = 1'b0;
    check("idle_accv_ignored", 32'(res_valid_o), 32'd0);

    // Row 1: len=4 id=3, acc_ready_i=1.
    row_valid_i = 1'b1; row_len_i = 16'd4; row_id_i = 4'd3;
    step();
    row_valid_i = 1'b0;
    check("r1_busy", 32'(busy_o), 32'd1);
    acc_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_add_valid_i = 1'b1; in_add_i = 32'(100 + i);
      in_mul_valid_i = (i == 1); in_mul_i = 32'h000000AB;
      #1;
      check("r1_add_valid", 32'(acc_add_valid_o), 32'd1);
      check("r1_add_data", acc_add_o, 32'(100 + i));
      check("r1_in_ready", 32'(in_add_ready_o), 32'd1);
      check("r1_last", 32'(acc_last_o), 32'(i == 3));
      if (i == 1) begin
        check("r1_mul_valid", 32'(acc_mul_valid_o), 32'd1);
        check("r1_mul_data", acc_mul_o, 32'h000000AB);
      end
      step();
    end
    in_add_valid_i = 1'b0; in_mul_valid_i = 1'b0;
    check("r1_invert", 32'(acc_invert_o), 32'd1);
    check("r1_inv_no_add", 32'(acc_add_valid_o), 32'd0);
    step();
    check("r1_invert_one", 32'(acc_invert_o), 32'd0);
    in_mul_valid_i = 1'b1;
    #1;
    check("r1_wait_mul_drop", 32'(acc_mul_valid_o), 32'd0);
    in_mul_valid_i = 1'b0;
    acc_valid_i = 1'b1; acc_i = 32'h3F800000;
    step();
    acc_valid_i = 1'b0; acc_i = 32'h0;
    check("r1_res_valid", 32'(res_valid_o), 32'd1);
    check("r1_res", res_o, 32'h3F800000);
    check("r1_res_id", 32'(res_id_o), 32'd3);
    // Hold result for 10 cycles while a new descriptor is offered.
    row_valid_i = 1'b1; row_len_i = 16'd1; row_id_i = 4'd9;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_res", res_o, 32'h3F800000);
      check("hold_id", 32'(res_id_o), 32'd3);
      check("hold_row_ready", 32'(row_ready_o), 32'd0);
      check("hold_valid", 32'(res_valid_o), 32'd1);
    end
    row_valid_i = 1'b0;
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("r1_clear", 32'(acc_clear_o), 32'd1);
    check("r1_clr_res_valid", 32'(res_valid_o), 32'd0);
    check("r1_clr_row_ready", 32'(row_ready_o), 32'd0);
    step();
    check("r1_clear_one", 32'(acc_clear_o), 32'd0);
    check("r1_idle_ready", 32'(row_ready_o), 32'd1);
    check("r1_idle_busy", 32'(busy_o), 32'd0);

    // Row 2: len=4 id=3 with acc_ready_i toggling every cycle.
    row_valid_i = 1'b1; row_len_i = 16'd4; row_id_i = 4'd3;
    step();
    row_valid_i = 1'b0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 4; c++) begin
      acc_ready_i = c[0];
      in_add_valid_i = 1'b1; in_add_i = 32'(200 + hs);
      #1;
      check("r2_add_data", acc_add_o, 32'(200 + hs));
      check("r2_in_ready", 32'(in_add_ready_o), 32'(c[0]));
      check("r2_last", 32'(acc_last_o), 32'(hs == 3));
      if (acc_ready_i) hs++;
      step();
    end
    in_add_valid_i = 1'b0; acc_ready_i = 1'b1;
    check("r2_handshakes", 32'(hs), 32'd4);
    check("r2_invert", 32'(acc_invert_o), 32'd1);
    step();
    acc_valid_i = 1'b1; acc_i = 32'h40000000;
    step();
    acc_valid_i = 1'b0;
    check("r2_res", res_o, 32'h40000000);
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("r2_clear", 32'(acc_clear_o), 32'd1);
    step();

    // Row 3: len=0 id=5 -> zero result, no invert/clear.
    row_valid_i = 1'b1; row_len_i = 16'd0; row_id_i = 4'd5;
    step();
    row_valid_i = 1'b0;
    check("r3_res_valid", 32'(res_valid_o), 32'd1);
    check("r3_res", res_o, 32'd0);
    check("r3_res_id", 32'(res_id_o), 32'd5);
    check("r3_no_invert", 32'(acc_invert_o), 32'd0);
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("r3_no_clear", 32'(acc_clear_o), 32'd0);
    check("r3_idle", 32'(row_ready_o), 32'd1);
    check("r3_busy", 32'(busy_o), 32'd0);

    // Row 4: len=8 id=7, aborted by clear_i after 2 addends.
    row_valid_i = 1'b1; row_len_i = 16'd8; row_id_i = 4'd7;
    step();
    row_valid_i = 1'b0;
    in_add_valid_i = 1'b1;
    step();
    step();
    in_add_valid_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clr_idle", 32'(row_ready_o), 32'd1);
    check("clr_busy", 32'(busy_o), 32'd0);
    check("clr_res_valid", 32'(res_valid_o), 32'd0);
    check("clr_res_id", 32'(res_id_o), 32'd0);

    // Row 5: len=1 id=2 completes normally after the abort.
    row_valid_i = 1'b1; row_len_i = 16'd1; row_id_i = 4'd2;
    step();
    row_valid_i = 1'b0;
    in_add_valid_i = 1'b1; in_add_i = 32'h11;
    #1;
    check("r5_last", 32'(acc_last_o), 32'd1);
    step();
    in_add_valid_i = 1'b0;
    check("r5_invert", 32'(acc_invert_o), 32'd1);
    step();
    acc_valid_i = 1'b1; acc_i = 32'h12345678;
    step();
    acc_valid_i = 1'b0;
    check("r5_res", res_o, 32'h12345678);
    check("r5_res_id", 32'(res_id_o), 32'd2);
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("r5_clear", 32'(acc_clear_o), 32'd1);
    step();
    check("r5_idle", 32'(row_ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
